// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch (read-only) and data (read/write) with a
// round-robin grant; fixed fetch priority when MEM_ARB_FETCH_PRIO_EN is defined.
module mem_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [1:0] cnt;
  logic       win_d;
  logic       pick_d;

`ifndef MEM_ARB_FETCH_PRIO_EN
  logic       last_d;
`endif

  always_comb begin
    pick_d = 1'b0;
`ifdef MEM_ARB_FETCH_PRIO_EN
    pick_d = !f_req;
`else
    // On a tie the port that was not granted last wins.
    pick_d = d_req && (!f_req || !last_d);
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      win_d     <= 1'b0;
`ifndef MEM_ARB_FETCH_PRIO_EN
      last_d    <= 1'b1;
`endif
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      f_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      mem_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            state     <= ISSUE;
            win_d     <= pick_d;
`ifndef MEM_ARB_FETCH_PRIO_EN
            last_d    <= pick_d;
`endif
            mem_en    <= 1'b1;
            mem_we    <= pick_d && d_we;
            mem_addr  <= pick_d ? d_addr : f_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
            f_gnt     <= !pick_d;
            d_gnt     <= pick_d;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          cnt    <= 2'(RD_LAT - 1);
          state  <= mem_we ? IDLE : WAIT;
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            if (win_d) d_rdata <= mem_rdata;
            else       f_rdata <= mem_rdata;
            d_rvalid <= win_d;
            f_rvalid <= !win_d;
            state    <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a RD_LAT=1 instance with a vector table and
// corner sequences, plus a RD_LAT=3 instance for latency and mid-transaction reset.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // RD_LAT = 1 instance
  logic        f_req, d_req, d_we;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic        f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  // RD_LAT = 3 instance
  logic        f_req3, d_req3, d_we3;
  logic [15:0] f_addr3, d_addr3, d_wdata3;
  logic        f_gnt3, f_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
  logic [15:0] f_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst),
    .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rvalid(f_rvalid3), .f_rdata(f_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Shared RAM model; read data is only valid for the cycles the latency allows,
  // otherwise it reads back as DEAD.
  logic [15:0] ram [0:1023];
  logic [15:0] rd1;
  logic [15:0] p3 [0:2];
  assign mem_rdata  = rd1;
  assign mem_rdata3 = p3[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 16'(i) ^ 16'h5A5A;
      ram[16] <= 16'hBEEF;
      rd1     <= 16'hDEAD;
      for (int i = 0; i < 3; i++) p3[i] <= 16'hDEAD;
    end else begin
      if (mem_en && mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      rd1   <= (mem_en && !mem_we) ? ram[mem_addr[9:0]] : 16'hDEAD;
      p3[0] <= (mem_en3 && !mem_we3) ? ram[mem_addr3[9:0]] : 16'hDEAD;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Both ports must never see gnt or rvalid in the same cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((f_gnt && d_gnt) || (f_rvalid && d_rvalid)) begin
        errors++;
        $display("FAIL exclusive_pulse: f_gnt=%b d_gnt=%b f_rvalid=%b d_rvalid=%b, expected one-hot",
                 f_gnt, d_gnt, f_rvalid, d_rvalid);
      end
    end
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_rv_cyc;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] exp_f_rdata, exp_d_rdata;

  task automatic run_vec(input int idx, input vec_t v);
    int          gnt_cyc, rv_cyc;
    logic        gnt_port, rv_port, g_en, g_we, busy2;
    logic [15:0] g_addr, g_wd, rdata;
    gnt_cyc = 0; rv_cyc = 0; gnt_port = 0; rv_port = 0; g_en = 0; g_we = 0; busy2 = 0;
    g_addr = 0; g_wd = 0; rdata = 0;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if ((f_gnt || d_gnt) && gnt_cyc == 0) begin
        gnt_cyc = c; gnt_port = d_gnt; g_en = mem_en; g_we = mem_we;
        g_addr = mem_addr; g_wd = mem_wdata;
        f_req = 1'b0; d_req = 1'b0;
      end
      if ((f_rvalid || d_rvalid) && rv_cyc == 0) begin
        rv_cyc = c; rv_port = d_rvalid; rdata = d_rvalid ? d_rdata : f_rdata;
      end
      if (c == 2) busy2 = busy;
    end
    chk($sformatf("v%0d_gnt_cycle", idx), 16'(gnt_cyc), 16'd1);
    chk($sformatf("v%0d_gnt_port", idx), 16'(gnt_port), 16'(v.is_d));
    chk($sformatf("v%0d_mem_en", idx), 16'(g_en), 16'd1);
    chk($sformatf("v%0d_mem_we", idx), 16'(g_we), 16'(v.we));
    chk($sformatf("v%0d_mem_addr", idx), g_addr, v.addr);
    chk($sformatf("v%0d_busy_cycle2", idx), 16'(busy2), 16'(!v.we));
    chk($sformatf("v%0d_rvalid_cycle", idx), 16'(rv_cyc), 16'(v.exp_rv_cyc));
    if (v.we) begin
      chk($sformatf("v%0d_mem_wdata", idx), g_wd, v.wdata);
    end else begin
      chk($sformatf("v%0d_rvalid_port", idx), 16'(rv_port), 16'(v.is_d));
      chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
      if (v.is_d) exp_d_rdata = v.exp_rdata;
      else        exp_f_rdata = v.exp_rdata;
    end
    chk($sformatf("v%0d_f_rdata_hold", idx), f_rdata, exp_f_rdata);
    chk($sformatf("v%0d_d_rdata_hold", idx), d_rdata, exp_d_rdata);
  endtask

  initial begin
    int          n, c0, c1, bcnt, rvcnt;
    logic        seq [4];
    logic        got_g, got_rv;
    logic [15:0] rdv;
    logic        exp_seq [4];

    rst = 1'b1;
    f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    f_req3 = 0; f_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;
    exp_f_rdata = 16'h0; exp_d_rdata = 16'h0;

    //           is_d we  addr      wdata     rv  rdata
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 0, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 3, 16'h1234};
    vecs[3] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 3, 16'h1234};
    vecs[4] = '{1'b1, 1'b1, 16'h0033, 16'hCAFE, 0, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'h0033, 16'h0000, 3, 16'hCAFE};
    vecs[6] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 3, 16'h5A5F};

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_pulses", {10'd0, f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we}, 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_f_rdata", f_rdata, 16'h0);
    chk("rst_d_rdata", d_rdata, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Contention with both reads held high from reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    f_req = 1'b1; f_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    n = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if ((f_gnt || d_gnt) && n < 4) begin
        seq[n] = d_gnt;
        n++;
      end
    end
`ifdef MEM_ARB_FETCH_PRIO_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    chk("contention_grant_count", 16'(n), 16'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("contention_grant%0d_is_data", i), 16'(seq[i]), 16'(exp_seq[i]));
    f_req = 1'b0;
    got_g = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (d_gnt && !got_g) begin got_g = 1'b1; d_req = 1'b0; end
    end
    d_req = 1'b0;
    chk("data_granted_after_fetch_drop", 16'(got_g), 16'd1);

    // Request withdrawn before any sampling edge: never served
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    #2 d_req = 1'b0;
    got_g = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_gnt || mem_en) got_g = 1'b1;
    end
    chk("withdrawn_before_capture_no_gnt", 16'(got_g), 16'd0);

    // Request dropped right after capture: still completes
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    @(posedge clk); #1 d_req = 1'b0;
    got_g = 1'b0; got_rv = 1'b0; rdv = 16'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_gnt) got_g = 1'b1;
      if (d_rvalid) begin got_rv = 1'b1; rdv = d_rdata; end
    end
    chk("dropped_after_capture_gnt", 16'(got_g), 16'd1);
    chk("dropped_after_capture_rvalid", 16'(got_rv), 16'd1);
    chk("dropped_after_capture_rdata", rdv, 16'hBEEF);

    // RD_LAT = 3 data read
    @(negedge clk);
    d_req3 = 1'b1; d_addr3 = 16'h0005;
    c0 = 0; c1 = 0; bcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (d_gnt3 && c0 == 0) begin c0 = c; d_req3 = 1'b0; end
      if (d_rvalid3 && c1 == 0) c1 = c;
      if (busy3) bcnt++;
    end
    chk("lat3_gnt_cycle", 16'(c0), 16'd1);
    chk("lat3_gnt_to_rvalid", 16'(c1 - c0), 16'd4);
    chk("lat3_busy_cycles", 16'(bcnt), 16'd5);
    chk("lat3_rdata", d_rdata3, 16'h5A5F);

    // Reset while waiting for read data
    @(negedge clk);
    d_req3 = 1'b1; d_addr3 = 16'h0010;
    @(negedge clk); d_req3 = 1'b0;
    @(negedge clk);
    chk("midwait_busy_before_reset", 16'(busy3), 16'd1);
    rst = 1'b1;
    #1;
    chk("midwait_rst_pulses", {11'd0, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3}, 16'h0);
    chk("midwait_rst_mem_addr", mem_addr3, 16'h0);
    chk("midwait_rst_d_rdata", d_rdata3, 16'h0);
    @(negedge clk); rst = 1'b0;
    rvcnt = 0; bcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_rvalid3 || d_gnt3) rvcnt++;
      if (busy3) bcnt++;
    end
    chk("midwait_no_pulse_after_release", 16'(rvcnt), 16'd0);
    chk("midwait_idle_after_release", 16'(bcnt), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
